snake_body_engine: RTL

Parametrised snake game-logic core for the VGA snake design. It holds up to MAX_LEN body segments on a cell grid and steps once per `tick` strobe. It also handles direction control with reversal rejection, growth on food, and wall and self-collision detection. A one-cycle-latency cell query port lets the pixel painter ask "is cell (x,y) snake?" without exposing the segment array.

---
 rtl/snake_body_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/snake_body_engine.sv
// Snake game core: shifting segment store, direction control with reversal rejection,
// growth on food, wall/self collision and a registered cell query. Macro: SNAKE_WRAP_EN.
module snake_body_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int COORD_W  = 6,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               tick,
    input  logic               BTN_L,
    input  logic               BTN_R,
    input  logic               BTN_U,
    input  logic               BTN_D,
    input  logic               restart,
    input  logic [COORD_W-1:0] food_x,
    input  logic [COORD_W-1:0] food_y,
    input  logic               food_valid,
    input  logic [COORD_W-1:0] q_x,
    input  logic [COORD_W-1:0] q_y,
    output logic               q_hit,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [LEN_W-1:0]   length,
    output logic [1:0]         state,
    output logic               eat,
    output logic               game_over
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;
    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {DIR_R = 2'd0, DIR_L = 2'd1, DIR_U = 2'd2, DIR_D = 2'd3} dir_t;

    localparam logic [COORD_W-1:0] MAX_X  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y  = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] MID_Y  = COORD_W'(GRID_H / 2);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [LEN_W-1:0]   INIT_L = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0]   MAX_L  = LEN_W'(MAX_LEN);

    state_t             state_reg, state_next;
    dir_t               dir_reg, dir_next, pend_reg, pend_next, req_dir;
    logic [LEN_W-1:0]   len_reg, len_next, body_lim;
    logic               eat_reg, eat_next, q_hit_reg;
    logic               step, reinit;
    logic               req_any, req_ok, at_edge, wall, food_hit, grow, self_hit;
    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];
    logic [COORD_W-1:0] nh_x, nh_y;
    logic [MAX_LEN-1:0] self_vec, q_vec;

    always_comb begin
        req_any = BTN_L | BTN_R | BTN_U | BTN_D;
        if (BTN_L)      req_dir = DIR_L;
        else if (BTN_R) req_dir = DIR_R;
        else if (BTN_U) req_dir = DIR_U;
        else            req_dir = DIR_D;
        req_ok = req_any && (req_dir != dir_t'(dir_reg ^ 2'b01));
    end

    // The step always follows pend, so a request made in the tick cycle waits a step.
    always_comb begin
        nh_x    = seg_x[0];
        nh_y    = seg_y[0];
        at_edge = 1'b0;
        case (pend_reg)
            DIR_R: begin at_edge = (seg_x[0] == MAX_X); nh_x = at_edge ? '0 : seg_x[0] + ONE; end
            DIR_L: begin at_edge = (seg_x[0] == '0); nh_x = at_edge ? MAX_X : seg_x[0] - ONE; end
            DIR_U: begin at_edge = (seg_y[0] == '0); nh_y = at_edge ? MAX_Y : seg_y[0] - ONE; end
            default: begin at_edge = (seg_y[0] == MAX_Y); nh_y = at_edge ? '0 : seg_y[0] + ONE; end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
`else
    assign wall = at_edge;
`endif

    assign food_hit = food_valid && (nh_x == food_x) && (nh_y == food_y);
    assign grow     = food_hit && (len_reg != MAX_L);
    // The tail cell is vacated this step unless the snake grows.
    assign body_lim = grow ? len_reg : len_reg - LEN_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
            assign self_vec[gi] = (LEN_W'(gi) < body_lim) && (seg_x[gi] == nh_x) && (seg_y[gi] == nh_y);
            assign q_vec[gi]    = (LEN_W'(gi) < len_reg) && (seg_x[gi] == q_x) && (seg_y[gi] == q_y);
        end
    endgenerate

    assign self_hit = |self_vec;

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        pend_next  = pend_reg;
        len_next   = len_reg;
        eat_next   = 1'b0;
        step       = 1'b0;
        reinit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    state_next = RUN;
                    if (req_ok) pend_next = req_dir;
                end
            end
            RUN: begin
                if (req_ok) pend_next = req_dir;
                if (tick) begin
                    dir_next = pend_reg;
                    if (wall || self_hit) begin
                        state_next = DEAD;
                    end else begin
                        step     = 1'b1;
                        eat_next = food_hit;
                        if (grow) len_next = len_reg + LEN_W'(1);
                    end
                end
            end
            DEAD: begin
                if (restart) begin
                    state_next = IDLE;
                    dir_next   = DIR_R;
                    pend_next  = DIR_R;
                    len_next   = INIT_L;
                    reinit     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            dir_reg   <= DIR_R;
            pend_reg  <= DIR_R;
            len_reg   <= INIT_L;
            eat_reg   <= 1'b0;
            q_hit_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            pend_reg  <= pend_next;
            len_reg   <= len_next;
            eat_reg   <= eat_next;
            q_hit_reg <= reinit ? 1'b0 : |q_vec;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? COORD_W'(INIT_LEN - 1 - i) : '0;
                seg_y[i] <= MID_Y;
            end
        end else if (reinit) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? COORD_W'(INIT_LEN - 1 - i) : '0;
                seg_y[i] <= MID_Y;
            end
        end else if (step) begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nh_x;
            seg_y[0] <= nh_y;
        end
    end

    assign q_hit     = q_hit_reg;
    assign head_x    = seg_x[0];
    assign head_y    = seg_y[0];
    assign length    = len_reg;
    assign state     = state_reg;
    assign eat       = eat_reg;
    assign game_over = (state_reg == DEAD);

endmodule
